interrupt_request_unit: RTL and testbench

//  Upstream of the multicycle Controller: collects external IRQ lines plus one NMI line,

---
 rtl/interrupt_request_unit_pkg.sv | 17 +
 rtl/interrupt_request_unit_priority_enc.sv | 22 ++
 rtl/interrupt_request_unit.sv | 148 ++++++++++++++
 tb/tb_interrupt_request_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/interrupt_request_unit_pkg.sv
// Shared definitions for the interrupt request unit: FSM state encodings,
// the NMI identifier and the default vector constants.
package interrupt_request_unit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_INT = 2'd1,
    REQ_NMI = 2'd2,
    SERVICE = 2'd3
  } irqState_e;

  localparam logic [3:0]  NMI_ID         = 4'hF;
  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;
  localparam logic [31:0] DEF_NMI_VEC    = 32'h0000_0080;

endpackage

// File: rtl/interrupt_request_unit_priority_enc.sv
// Combinational lowest-index finder over the enabled pending request vector.
module irq_priority_enc #(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               any,
  output logic [3:0]         idx
);

  always_comb begin
    any = 1'b0;
    idx = 4'd0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_request_unit.sv
// Edge-latching interrupt request unit feeding the Controller INT/NMI handshake.
// Optional build macro IRQ_MASK_EN adds a writable enable mask (mask_we/mask_wdata).
module interrupt_request_unit
  import interrupt_request_unit_pkg::*;
#(
  parameter int                NUM_IRQ    = 8,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(DEF_VEC_BASE),
  parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(DEF_VEC_STRIDE),
  parameter logic [ADDR_W-1:0] NMI_VEC    = ADDR_W'(DEF_NMI_VEC)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               nmi_in,
  input  logic               INA,
  input  logic               eoi,
`ifdef IRQ_MASK_EN
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
`endif
  output logic               INT,
  output logic               NMI,
  output logic [ADDR_W-1:0]  irq_vector,
  output logic [3:0]         irq_id,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending
);

  irqState_e            state, stateNext;
  logic [NUM_IRQ-1:0]   prevIrq;
  logic                 prevNmi;
  logic                 nmiPend;
  logic [NUM_IRQ-1:0]   enabled;
  logic [NUM_IRQ-1:0]   clrIrq;
  logic                 clrNmi;
  logic                 anyReq;
  logic [3:0]           reqIdx;
  logic                 intNext, nmiNext, svcNext;
  logic [3:0]           idNext;
  logic [ADDR_W-1:0]    vecNext;

  function automatic logic [ADDR_W-1:0] vecFor(input logic [3:0] idx);
    return VEC_BASE + ADDR_W'(idx) * VEC_STRIDE;
  endfunction

`ifdef IRQ_MASK_EN
  logic [NUM_IRQ-1:0] maskReg;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)          maskReg <= '1;
    else if (mask_we) maskReg <= mask_wdata;
  end

  assign enabled = maskReg;
`else
  assign enabled = '1;
`endif

  irq_priority_enc #(.NUM_IRQ(NUM_IRQ)) uPrioEnc (
    .req (pending & enabled),
    .any (anyReq),
    .idx (reqIdx)
  );

  always_comb begin
    stateNext = state;
    intNext   = 1'b0;
    nmiNext   = 1'b0;
    svcNext   = 1'b0;
    idNext    = irq_id;
    vecNext   = irq_vector;
    clrIrq    = '0;
    clrNmi    = 1'b0;
    case (state)
      IDLE: begin
        if (nmiPend) begin
          stateNext = REQ_NMI;
          nmiNext   = 1'b1;
          idNext    = NMI_ID;
          vecNext   = NMI_VEC;
        end else if (anyReq) begin
          stateNext = REQ_INT;
          intNext   = 1'b1;
          idNext    = reqIdx;
          vecNext   = vecFor(reqIdx);
        end
      end
      REQ_INT: begin
        // Ack beats a concurrently pending NMI; otherwise NMI pre-empts the request.
        if (INA) begin
          clrIrq    = NUM_IRQ'(1) << irq_id;
          stateNext = SERVICE;
          svcNext   = 1'b1;
        end else if (nmiPend) begin
          stateNext = REQ_NMI;
          nmiNext   = 1'b1;
          idNext    = NMI_ID;
          vecNext   = NMI_VEC;
        end else begin
          intNext   = 1'b1;
        end
      end
      REQ_NMI: begin
        if (INA) begin
          clrNmi    = 1'b1;
          stateNext = SERVICE;
          svcNext   = 1'b1;
        end else begin
          nmiNext   = 1'b1;
        end
      end
      SERVICE: begin
        if (eoi) stateNext = IDLE;
        else     svcNext   = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  // New edges are OR-ed in after the clear so a same-cycle edge keeps the bit set.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      prevIrq    <= '0;
      prevNmi    <= 1'b0;
      pending    <= '0;
      nmiPend    <= 1'b0;
      INT        <= 1'b0;
      NMI        <= 1'b0;
      in_service <= 1'b0;
      irq_id     <= 4'd0;
      irq_vector <= '0;
    end else begin
      state      <= stateNext;
      prevIrq    <= irq_in;
      prevNmi    <= nmi_in;
      pending    <= (pending & ~clrIrq) | (irq_in & ~prevIrq);
      nmiPend    <= (nmiPend & ~clrNmi) | (nmi_in & ~prevNmi);
      INT        <= intNext;
      NMI        <= nmiNext;
      in_service <= svcNext;
      irq_id     <= idNext;
      irq_vector <= vecNext;
    end
  end

endmodule

// File: tb/tb_interrupt_request_unit.sv
// Directed self-checking bench for interrupt_request_unit (8 IRQ lines, default vectors).
module tb_interrupt_request_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [7:0]  irq_in;
  logic        nmi_in, INA, eoi;
  logic        INT, NMI, in_service;
  logic [31:0] irq_vector;
  logic [3:0]  irq_id;
  logic [7:0]  pending;
`ifdef IRQ_MASK_EN
  logic        mask_we;
  logic [7:0]  mask_wdata;
`endif

  int checks   = 0;
  int failures = 0;

  interrupt_request_unit dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .irq_in     (irq_in),
    .nmi_in     (nmi_in),
    .INA        (INA),
    .eoi        (eoi),
`ifdef IRQ_MASK_EN
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
`endif
    .INT        (INT),
    .NMI        (NMI),
    .irq_vector (irq_vector),
    .irq_id     (irq_id),
    .in_service (in_service),
    .pending    (pending)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; irq_in = '0; nmi_in = 1'b0; INA = 1'b0; eoi = 1'b0;
`ifdef IRQ_MASK_EN
    mask_we = 1'b0; mask_wdata = '0;
`endif
    tick(2);
    checks++; if ({INT, NMI, in_service} !== 3'b000) begin failures++; $display("FAIL reset_ctl got=%b exp=000", {INT, NMI, in_service}); end
    checks++; if (irq_vector !== 32'h0 || irq_id !== 4'h0) begin failures++; $display("FAIL reset_vec got vec=%h id=%h exp 0/0", irq_vector, irq_id); end
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL reset_pend got=%h exp=00", pending); end
    Rst = 1'b0;
    tick(2);
    checks++; if (INT !== 1'b0 || NMI !== 1'b0) begin failures++; $display("FAIL idle_after_reset INT=%b NMI=%b exp 0 0", INT, NMI); end
  endtask

  task automatic test_basic();
    irq_in[3] = 1'b1;
    tick();
    checks++; if (pending !== 8'h08 || INT !== 1'b0) begin failures++; $display("FAIL basic_latch pend=%h INT=%b exp 08 0", pending, INT); end
    tick();
    checks++; if (INT !== 1'b1) begin failures++; $display("FAIL basic_int got=%b exp=1", INT); end
    checks++; if (irq_id !== 4'd3 || irq_vector !== 32'h130) begin failures++; $display("FAIL basic_vec id=%h vec=%h exp 3 130", irq_id, irq_vector); end
    INA = 1'b1; tick(); INA = 1'b0;
    checks++; if (pending[3] !== 1'b0 || in_service !== 1'b1 || INT !== 1'b0) begin failures++; $display("FAIL basic_ack pend=%h svc=%b INT=%b exp 0 1 0", pending, in_service, INT); end
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++; if (in_service !== 1'b0) begin failures++; $display("FAIL basic_eoi svc=%b exp=0", in_service); end
    tick(2);
    checks++; if (INT !== 1'b0) begin failures++; $display("FAIL basic_quiet INT=%b exp=0", INT); end
    irq_in[3] = 1'b0; tick();
  endtask

  task automatic test_priority();
    irq_in[5] = 1'b1; irq_in[2] = 1'b1;
    tick();
    checks++; if (pending !== 8'h24) begin failures++; $display("FAIL prio_pend got=%h exp=24", pending); end
    tick();
    checks++; if (INT !== 1'b1 || irq_id !== 4'd2 || irq_vector !== 32'h120) begin failures++; $display("FAIL prio_first INT=%b id=%h vec=%h exp 1 2 120", INT, irq_id, irq_vector); end
    INA = 1'b1; tick(); INA = 1'b0;
    checks++; if (pending !== 8'h20) begin failures++; $display("FAIL prio_clr got=%h exp=20", pending); end
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++; if (INT !== 1'b0) begin failures++; $display("FAIL prio_gap INT=%b exp=0", INT); end
    tick();
    checks++; if (INT !== 1'b1 || irq_id !== 4'd5 || irq_vector !== 32'h150) begin failures++; $display("FAIL prio_second INT=%b id=%h vec=%h exp 1 5 150", INT, irq_id, irq_vector); end
    INA = 1'b1; tick(); INA = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    irq_in[5] = 1'b0; irq_in[2] = 1'b0; tick();
  endtask

  task automatic test_nmi_preempt();
    irq_in[4] = 1'b1;
    tick(2);
    checks++; if (INT !== 1'b1 || irq_id !== 4'd4) begin failures++; $display("FAIL nmi_pre_req INT=%b id=%h exp 1 4", INT, irq_id); end
    nmi_in = 1'b1;
    tick();
    checks++; if (INT !== 1'b1 || NMI !== 1'b0) begin failures++; $display("FAIL nmi_latch INT=%b NMI=%b exp 1 0", INT, NMI); end
    tick();
    checks++; if (INT !== 1'b0 || NMI !== 1'b1) begin failures++; $display("FAIL nmi_switch INT=%b NMI=%b exp 0 1", INT, NMI); end
    checks++; if (irq_vector !== 32'h80 || irq_id !== 4'hF || pending[4] !== 1'b1) begin failures++; $display("FAIL nmi_vec vec=%h id=%h pend=%h exp 80 F bit4", irq_vector, irq_id, pending); end
    INA = 1'b1; tick(); INA = 1'b0;
    checks++; if (NMI !== 1'b0 || in_service !== 1'b1) begin failures++; $display("FAIL nmi_ack NMI=%b svc=%b exp 0 1", NMI, in_service); end
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    checks++; if (INT !== 1'b1 || irq_id !== 4'd4 || irq_vector !== 32'h140) begin failures++; $display("FAIL nmi_resume INT=%b id=%h vec=%h exp 1 4 140", INT, irq_id, irq_vector); end
    INA = 1'b1; tick(); INA = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    irq_in[4] = 1'b0; nmi_in = 1'b0; tick();
  endtask

  task automatic test_held_level();
    irq_in[1] = 1'b1;
    tick(2);
    checks++; if (INT !== 1'b1 || irq_id !== 4'd1) begin failures++; $display("FAIL held_first INT=%b id=%h exp 1 1", INT, irq_id); end
    INA = 1'b1; tick(); INA = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick(3);
    checks++; if (INT !== 1'b0 || pending !== 8'h00) begin failures++; $display("FAIL held_no_rereq INT=%b pend=%h exp 0 00", INT, pending); end
    irq_in[1] = 1'b0; tick();
    irq_in[1] = 1'b1; tick(2);
    checks++; if (INT !== 1'b1 || irq_id !== 4'd1) begin failures++; $display("FAIL held_reraise INT=%b id=%h exp 1 1", INT, irq_id); end
    INA = 1'b1; tick(); INA = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    irq_in[1] = 1'b0; tick();
  endtask

  task automatic test_set_wins();
    irq_in[6] = 1'b1;
    tick(2);
    irq_in[6] = 1'b0; tick();
    irq_in[6] = 1'b1; INA = 1'b1;
    tick();
    INA = 1'b0;
    checks++; if (in_service !== 1'b1 || pending[6] !== 1'b1) begin failures++; $display("FAIL setwins svc=%b pend=%h exp 1 bit6", in_service, pending); end
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    checks++; if (INT !== 1'b1 || irq_id !== 4'd6) begin failures++; $display("FAIL setwins_rereq INT=%b id=%h exp 1 6", INT, irq_id); end
    INA = 1'b1; tick(); INA = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    irq_in[6] = 1'b0; tick();
  endtask

  task automatic test_ignored();
    INA = 1'b1; eoi = 1'b1; tick(2); INA = 1'b0; eoi = 1'b0;
    checks++; if ({INT, NMI, in_service} !== 3'b000 || pending !== 8'h00) begin failures++; $display("FAIL ignored ctl=%b pend=%h exp 000 00", {INT, NMI, in_service}, pending); end
  endtask

`ifdef IRQ_MASK_EN
  task automatic test_mask();
    mask_we = 1'b1; mask_wdata = 8'hFE; tick(); mask_we = 1'b0;
    irq_in[0] = 1'b1; tick(2);
    checks++; if (pending[0] !== 1'b1 || INT !== 1'b0) begin failures++; $display("FAIL mask_hold pend=%h INT=%b exp bit0 0", pending, INT); end
    mask_we = 1'b1; mask_wdata = 8'hFF; tick(); mask_we = 1'b0;
    tick();
    checks++; if (INT !== 1'b1 || irq_id !== 4'd0 || irq_vector !== 32'h100) begin failures++; $display("FAIL mask_release INT=%b id=%h vec=%h exp 1 0 100", INT, irq_id, irq_vector); end
    INA = 1'b1; tick(); INA = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    irq_in[0] = 1'b0; tick();
  endtask
`endif

  task automatic test_rst_service();
    irq_in[7] = 1'b1;
    tick(2);
    INA = 1'b1; tick(); INA = 1'b0;
    checks++; if (in_service !== 1'b1 || irq_id !== 4'd7) begin failures++; $display("FAIL rst_pre svc=%b id=%h exp 1 7", in_service, irq_id); end
    irq_in[0] = 1'b1; tick();
    #2 Rst = 1'b1;
    #1;
    checks++; if ({INT, NMI, in_service} !== 3'b000 || irq_vector !== 32'h0 || irq_id !== 4'h0 || pending !== 8'h00) begin failures++; $display("FAIL rst_async ctl=%b vec=%h id=%h pend=%h exp all 0", {INT, NMI, in_service}, irq_vector, irq_id, pending); end
    irq_in = '0;
    tick();
    Rst = 1'b0;
    tick(3);
    checks++; if ({INT, NMI, in_service} !== 3'b000 || pending !== 8'h00) begin failures++; $display("FAIL rst_idle ctl=%b pend=%h exp 000 00", {INT, NMI, in_service}, pending); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_nmi_preempt();
    test_held_level();
    test_set_wins();
    test_ignored();
`ifdef IRQ_MASK_EN
    test_mask();
`endif
    test_rst_service();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
